// File: rtl/pipe_pkg.sv
// Shared constants for flow-controlled pipeline stages: default field widths,
// the two-valid-bit state encoding and the payload width helper.
package pipe_pkg;

    localparam int CTRL_W   = 16;
    localparam int DATA_W   = 16;
    localparam int REGNUM_W = 4;
    localparam int SP_W     = 32;

    // State is literally {skid_valid, main_valid}; 2'b10 cannot occur.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_FULL  = 2'b01;
    localparam logic [1:0] ST_SKID  = 2'b11;

    function automatic int payload_width(input int ctrl_w, input int data_w,
                                         input int regnum_w, input int sp_w);
        return ctrl_w + 2 * data_w + regnum_w + sp_w;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline holding slot: a valid bit plus payload register. Clear wins over
// load and drops only the valid bit, so the payload keeps its last value.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int WIDTH = payload_width(CTRL_W, DATA_W, REGNUM_W, SP_W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic             valid,
    output logic [WIDTH-1:0] q
);

    // NOTE: state updates use <= so every flop samples pre-edge values; = here would create ordering races.
    // NOTE: the payload is reset too, because a reset stage must present all-zero outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/mw_pipeline_stage.sv
// Memory/Writeback pipeline register with valid/ready handshake, one-entry skid
// buffer, flush and bubble control-zeroing. Define MW_PIPELINE_STAGE_STATS_EN for stall/bubble counters.
module mw_pipeline_stage
    import pipe_pkg::*;
#(
    parameter int NUMBER_CONTROL_SIGNALS = CTRL_W,
    parameter int DATA_WIDTH             = DATA_W,
    parameter int REG_NUM_WIDTH          = REGNUM_W,
    parameter int SP_WIDTH               = SP_W
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush_IN,
    input  logic                              valid_IN,
    output logic                              ready_OUT,
    input  logic [NUMBER_CONTROL_SIGNALS-1:0] control_sinals_IN,
    input  logic [DATA_WIDTH-1:0]             result_IN,
    input  logic [REG_NUM_WIDTH-1:0]          reg_dst_num_IN,
    input  logic [DATA_WIDTH-1:0]             reg_dst_value_IN,
    input  logic [SP_WIDTH-1:0]               sp_Reg_IN,
    output logic                              valid_OUT,
    input  logic                              ready_IN,
    output logic [NUMBER_CONTROL_SIGNALS-1:0] control_sinals_OUT,
    output logic [DATA_WIDTH-1:0]             result_OUT,
    output logic [REG_NUM_WIDTH-1:0]          reg_dst_num_OUT,
    output logic [DATA_WIDTH-1:0]             reg_dst_value_OUT,
    output logic [SP_WIDTH-1:0]               sp_Reg_OUT
`ifdef MW_PIPELINE_STAGE_STATS_EN
    ,
    output logic [15:0]                       stall_count_OUT,
    output logic [15:0]                       bubble_count_OUT
`endif
);

    localparam int PW = payload_width(NUMBER_CONTROL_SIGNALS, DATA_WIDTH, REG_NUM_WIDTH, SP_WIDTH);

    logic [PW-1:0] payload_in;
    logic [PW-1:0] main_d;
    logic [PW-1:0] main_q;
    logic [PW-1:0] skid_q;
    logic          main_valid;
    logic          skid_valid;
    logic          main_load;
    logic          main_clear;
    logic          main_sel_skid;
    logic          skid_load;
    logic          skid_clear;
    logic          up_xfer;
    logic          down_xfer;
    logic [1:0]    state;
    logic [NUMBER_CONTROL_SIGNALS-1:0] ctrl_q;

    assign payload_in = {control_sinals_IN, result_IN, reg_dst_num_IN, reg_dst_value_IN, sp_Reg_IN};

    assign ready_OUT = !skid_valid;
    assign valid_OUT = main_valid;
    assign up_xfer   = valid_IN && ready_OUT;
    assign down_xfer = main_valid && ready_IN;
    assign state     = {skid_valid, main_valid};

    // NOTE: every strobe gets a default before the case, so no path leaves one unassigned (no latches).
    always_comb begin
        main_load     = 1'b0;
        main_clear    = 1'b0;
        main_sel_skid = 1'b0;
        skid_load     = 1'b0;
        skid_clear    = 1'b0;
        case (state)
            ST_EMPTY: main_load = up_xfer;
            ST_FULL: begin
                if (down_xfer && up_xfer) main_load  = 1'b1;
                else if (down_xfer)       main_clear = 1'b1;
                else if (up_xfer)         skid_load  = 1'b1;
            end
            ST_SKID: begin
                if (down_xfer) begin
                    main_load     = 1'b1;
                    main_sel_skid = 1'b1;
                    skid_clear    = 1'b1;
                end
            end
            default: skid_clear = 1'b1;
        endcase
        // Flush overrides every transfer; slot clears take priority over loads.
        if (flush_IN) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end
    end

    assign main_d = main_sel_skid ? skid_q : payload_in;

    pipe_slot #(.WIDTH(PW)) u_main (
        .clk   (clk),
        .reset (reset),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .valid (main_valid),
        .q     (main_q)
    );

    pipe_slot #(.WIDTH(PW)) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (payload_in),
        .valid (skid_valid),
        .q     (skid_q)
    );

    assign {ctrl_q, result_OUT, reg_dst_num_OUT, reg_dst_value_OUT, sp_Reg_OUT} = main_q;
    // Bubbles carry zero control so no write-enable fires downstream.
    assign control_sinals_OUT = main_valid ? ctrl_q : '0;

`ifdef MW_PIPELINE_STAGE_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count_OUT  <= '0;
            bubble_count_OUT <= '0;
        end else if (flush_IN) begin
            stall_count_OUT  <= '0;
            bubble_count_OUT <= '0;
        end else begin
            if (main_valid && !ready_IN && stall_count_OUT != 16'hFFFF)
                stall_count_OUT <= stall_count_OUT + 16'd1;
            if (!main_valid && bubble_count_OUT != 16'hFFFF)
                bubble_count_OUT <= bubble_count_OUT + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mw_pipeline_stage.sv
// Self-checking bench for mw_pipeline_stage: directed scenarios plus a randomized
// run against a two-entry FIFO reference model.
module tb_mw_pipeline_stage;

    typedef struct packed {
        logic [15:0] ctrl;
        logic [15:0] res;
        logic [3:0]  rn;
        logic [15:0] rv;
        logic [31:0] sp;
    } beat_t;

    logic        clk;
    logic        reset;
    logic        flush_IN;
    logic        valid_IN;
    logic        ready_OUT;
    logic [15:0] control_sinals_IN;
    logic [15:0] result_IN;
    logic [3:0]  reg_dst_num_IN;
    logic [15:0] reg_dst_value_IN;
    logic [31:0] sp_Reg_IN;
    logic        valid_OUT;
    logic        ready_IN;
    logic [15:0] control_sinals_OUT;
    logic [15:0] result_OUT;
    logic [3:0]  reg_dst_num_OUT;
    logic [15:0] reg_dst_value_OUT;
    logic [31:0] sp_Reg_OUT;
`ifdef MW_PIPELINE_STAGE_STATS_EN
    logic [15:0] stall_count_OUT;
    logic [15:0] bubble_count_OUT;
`endif

    beat_t out_beat;
    int    n_vec = 0;
    int    n_err = 0;

    mw_pipeline_stage dut (
        .clk                (clk),
        .reset              (reset),
        .flush_IN           (flush_IN),
        .valid_IN           (valid_IN),
        .ready_OUT          (ready_OUT),
        .control_sinals_IN  (control_sinals_IN),
        .result_IN          (result_IN),
        .reg_dst_num_IN     (reg_dst_num_IN),
        .reg_dst_value_IN   (reg_dst_value_IN),
        .sp_Reg_IN          (sp_Reg_IN),
        .valid_OUT          (valid_OUT),
        .ready_IN           (ready_IN),
        .control_sinals_OUT (control_sinals_OUT),
        .result_OUT         (result_OUT),
        .reg_dst_num_OUT    (reg_dst_num_OUT),
        .reg_dst_value_OUT  (reg_dst_value_OUT),
        .sp_Reg_OUT         (sp_Reg_OUT)
`ifdef MW_PIPELINE_STAGE_STATS_EN
        ,
        .stall_count_OUT    (stall_count_OUT),
        .bubble_count_OUT   (bubble_count_OUT)
`endif
    );

    assign out_beat = {control_sinals_OUT, result_OUT, reg_dst_num_OUT, reg_dst_value_OUT, sp_Reg_OUT};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input beat_t b);
        valid_IN = v;
        {control_sinals_IN, result_IN, reg_dst_num_IN, reg_dst_value_IN, sp_Reg_IN} = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_vec++;
        if (out_beat !== '0 || {valid_OUT, ready_OUT} !== 2'b01) begin
            n_err++;
            $display("FAIL reset_async: out=%h v/r=%b want out=0 v/r=01", out_beat, {valid_OUT, ready_OUT});
        end
        drive(1'b1, beat_t'({16'hFFFF, 16'h1234, 4'h5, 16'h6789, 32'hDEAD_BEEF}));
        tick();
        n_vec++;
        if (out_beat !== '0 || {valid_OUT, ready_OUT} !== 2'b01) begin
            n_err++;
            $display("FAIL reset_hold: out=%h v/r=%b want out=0 v/r=01", out_beat, {valid_OUT, ready_OUT});
        end
        drive(1'b0, '0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        n_vec++;
        if ({valid_OUT, ready_OUT} !== 2'b01) begin
            n_err++;
            $display("FAIL reset_release: v/r=%b want 01", {valid_OUT, ready_OUT});
        end
    endtask

    task automatic test_streaming();
        beat_t b;
        ready_IN = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            b = '{ctrl: 16'h0100 | 16'(i), res: 16'(i), rn: 4'(i), rv: 16'(i * 3), sp: 32'(i * 7)};
            drive(1'b1, b);
            tick();
            n_vec++;
            if (valid_OUT !== 1'b1 || out_beat !== b) begin
                n_err++;
                $display("FAIL stream beat %0d: v=%b out=%h want v=1 out=%h", i, valid_OUT, out_beat, b);
            end
        end
        drive(1'b0, '0);
        tick();
        n_vec++;
        if (valid_OUT !== 1'b0 || result_OUT !== 16'h0008) begin
            n_err++;
            $display("FAIL stream drain: v=%b res=%h want v=0 res=0008", valid_OUT, result_OUT);
        end
    endtask

    task automatic test_back_pressure();
        // {ready_IN, valid_IN, result_IN, exp valid_OUT, exp ready_OUT, exp result_OUT}
        logic [35:0] steps [7];
        steps[0] = {1'b1, 1'b1, 16'h00A1, 1'b1, 1'b1, 16'h00A1};
        steps[1] = {1'b0, 1'b1, 16'h00A2, 1'b1, 1'b0, 16'h00A1};
        steps[2] = {1'b0, 1'b1, 16'h00A3, 1'b1, 1'b0, 16'h00A1};
        steps[3] = {1'b0, 1'b1, 16'h00A3, 1'b1, 1'b0, 16'h00A1};
        steps[4] = {1'b1, 1'b1, 16'h00A3, 1'b1, 1'b1, 16'h00A2};
        steps[5] = {1'b1, 1'b1, 16'h00A3, 1'b1, 1'b1, 16'h00A3};
        steps[6] = {1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h00A3};
        for (int i = 0; i < 7; i++) begin
            ready_IN = steps[i][35];
            drive(steps[i][34], beat_t'({16'h0002, steps[i][33:18], 4'h1, 16'h0, 32'h0}));
            tick();
            n_vec++;
            if ({valid_OUT, ready_OUT, result_OUT} !== steps[i][17:0]) begin
                n_err++;
                $display("FAIL backpressure step %0d: v/r/res=%h want %h", i,
                         {valid_OUT, ready_OUT, result_OUT}, steps[i][17:0]);
            end
        end
    endtask

    task automatic test_flush();
        ready_IN = 1'b0;
        drive(1'b1, beat_t'({16'h0011, 16'h00B1, 4'h1, 16'h0, 32'h0}));
        tick();
        drive(1'b1, beat_t'({16'h0022, 16'h00B2, 4'h2, 16'h0, 32'h0}));
        tick();
        n_vec++;
        if (ready_OUT !== 1'b0) begin
            n_err++;
            $display("FAIL flush_setup ready_OUT: got %b want 0", ready_OUT);
        end
        flush_IN = 1'b1;
        drive(1'b1, beat_t'({16'hFFFF, 16'h00B3, 4'h3, 16'h0, 32'h0}));
        tick();
        flush_IN = 1'b0;
        drive(1'b0, '0);
        n_vec++;
        if ({valid_OUT, ready_OUT, control_sinals_OUT, result_OUT} !== {1'b0, 1'b1, 16'h0000, 16'h00B1}) begin
            n_err++;
            $display("FAIL flush: v=%b r=%b ctrl=%h res=%h want v=0 r=1 ctrl=0000 res=00B1",
                     valid_OUT, ready_OUT, control_sinals_OUT, result_OUT);
        end
        ready_IN = 1'b1;
        tick();
        n_vec++;
        if (valid_OUT !== 1'b0) begin
            n_err++;
            $display("FAIL flush_dropped_beat: v=%b want 0", valid_OUT);
        end
    endtask

    task automatic test_bubble();
        ready_IN = 1'b1;
        drive(1'b1, beat_t'({16'h8003, 16'h0C0C, 4'hA, 16'h5555, 32'h1000}));
        tick();
        n_vec++;
        if ({valid_OUT, control_sinals_OUT} !== {1'b1, 16'h8003}) begin
            n_err++;
            $display("FAIL bubble_beat: v=%b ctrl=%h want v=1 ctrl=8003", valid_OUT, control_sinals_OUT);
        end
        drive(1'b0, '0);
        for (int i = 0; i < 2; i++) begin
            tick();
            n_vec++;
            if ({valid_OUT, control_sinals_OUT, reg_dst_num_OUT} !== {1'b0, 16'h0000, 4'hA}) begin
                n_err++;
                $display("FAIL bubble %0d: v=%b ctrl=%h rn=%h want v=0 ctrl=0000 rn=A",
                         i, valid_OUT, control_sinals_OUT, reg_dst_num_OUT);
            end
        end
    endtask

    task automatic test_reset_mid();
        ready_IN = 1'b0;
        drive(1'b1, beat_t'({16'h00C1, 16'h00C1, 4'h1, 16'h1, 32'h1}));
        tick();
        drive(1'b1, beat_t'({16'h00C2, 16'h00C2, 4'h2, 16'h2, 32'h2}));
        tick();
        #3;
        reset = 1'b0;
        #1;
        n_vec++;
        if (out_beat !== '0 || {valid_OUT, ready_OUT} !== 2'b01) begin
            n_err++;
            $display("FAIL reset_mid: out=%h v/r=%b want out=0 v/r=01", out_beat, {valid_OUT, ready_OUT});
        end
        tick();
        n_vec++;
        if (out_beat !== '0 || {valid_OUT, ready_OUT} !== 2'b01) begin
            n_err++;
            $display("FAIL reset_mid_hold: out=%h v/r=%b want out=0 v/r=01", out_beat, {valid_OUT, ready_OUT});
        end
        drive(1'b0, '0);
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    // Reference: the stage is a 2-deep FIFO; outputs show the head, or the last head when empty.
    task automatic test_random();
        beat_t q[$];
        beat_t last_head = '0;
        beat_t b;
        beat_t exp_beat;
        logic  v, r, f, pre_ready;
        for (int n = 0; n < 400; n++) begin
            v = ($urandom_range(0, 9) < 6);
            r = ($urandom_range(0, 9) < 6);
            f = ($urandom_range(0, 19) == 0);
            if (v) b = {16'($urandom), 16'($urandom), 4'($urandom), 16'($urandom), 32'($urandom)};
            else   b = 'x;
            flush_IN = f;
            ready_IN = r;
            drive(v, b);
            pre_ready = (q.size() < 2);
            if (f) begin
                q.delete();
            end else begin
                if (q.size() != 0 && r) void'(q.pop_front());
                if (v && pre_ready) q.push_back(b);
            end
            if (q.size() != 0) last_head = q[0];
            tick();
            exp_beat = last_head;
            if (q.size() == 0) exp_beat.ctrl = '0;
            n_vec++;
            if ({valid_OUT, ready_OUT} !== {q.size() != 0, q.size() < 2}) begin
                n_err++;
                $display("FAIL random %0d handshake: v/r=%b want %b", n, {valid_OUT, ready_OUT},
                         {q.size() != 0, q.size() < 2});
            end
            n_vec++;
            if (out_beat !== exp_beat) begin
                n_err++;
                $display("FAIL random %0d payload: got %h want %h", n, out_beat, exp_beat);
            end
        end
        flush_IN = 1'b0;
        drive(1'b0, '0);
    endtask

`ifdef MW_PIPELINE_STAGE_STATS_EN
    task automatic test_stats();
        flush_IN = 1'b1;
        tick();
        flush_IN = 1'b0;
        ready_IN = 1'b0;
        drive(1'b1, beat_t'({16'h0001, 16'h0EEE, 4'h1, 16'h0, 32'h0}));
        tick();
        drive(1'b0, '0);
        repeat (70000) tick();
        n_vec++;
        if (stall_count_OUT !== 16'hFFFF) begin
            n_err++;
            $display("FAIL stats_saturate: stall=%h want FFFF", stall_count_OUT);
        end
        flush_IN = 1'b1;
        tick();
        flush_IN = 1'b0;
        n_vec++;
        if ({stall_count_OUT, bubble_count_OUT} !== 32'h0) begin
            n_err++;
            $display("FAIL stats_flush: stall=%h bubble=%h want 0000 0000", stall_count_OUT, bubble_count_OUT);
        end
    endtask
`endif

    initial begin
        reset    = 1'b0;
        flush_IN = 1'b0;
        ready_IN = 1'b0;
        drive(1'b0, '0);
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush();
        test_bubble();
        test_reset_mid();
        test_random();
`ifdef MW_PIPELINE_STAGE_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
